button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//   Upstream conditioning stage for the laser surgery FSM's `button` input.
//   Synchronises the raw asynchronous push-button, rejects bounce shorter than
//   DEBOUNCE_CYCLES clocks and emits a one-cycle press pulse plus a clean level.
//   button_pulse drives the FSM `button` input directly: one pulse per physical press.
// PARAMETERS
//   NBITS            32   width of the internal stability counter
//   DEBOUNCE_CYCLES  16   consecutive stable synchronised samples needed to accept a change; 2 <= D < 2**NBITS
// PORTS
//   clk           in   1   single system clock, all state updates on posedge
//   reset         in   1   synchronous, active-high reset
//   button_raw    in   1   raw, asynchronous, bouncing push-button (1 = pressed)
//   button_level  out  1   debounced, registered button level
//   button_pulse  out  1   registered, 1-cycle strobe on each accepted press
// BEHAVIOUR
//   - Reset: reset is synchronous and active-high, sampled only on posedge clk.
//     sync1, sync2, cnt <= 0; state <= IDLE; button_level, button_pulse <= 0.
//   - Synchroniser: sync1 <= button_raw; sync2 <= sync1. The FSM sees only sync2.
//   - FSM states and transitions (evaluated each posedge; D = DEBOUNCE_CYCLES):
//     IDLE      : stable low. sync2=1 -> WAIT_HIGH, cnt <= 1.
//     WAIT_HIGH : sync2=0 -> IDLE, cnt <= 0 (bounce rejected, no pulse).
//                 sync2=1 & cnt==D-1 -> HIGH, button_pulse <= 1, button_level <= 1.
//                 sync2=1 otherwise -> cnt <= cnt+1.
//     HIGH      : stable high. sync2=0 -> WAIT_LOW, cnt <= 1.
//     WAIT_LOW  : sync2=1 -> HIGH, cnt <= 0 (level stays 1, no new pulse).
//                 sync2=0 & cnt==D-1 -> IDLE, button_level <= 0.
//                 sync2=0 otherwise -> cnt <= cnt+1.
//   - button_pulse is 1 for exactly one cycle, only on the WAIT_HIGH->HIGH edge.
//     It is 0 in every other cycle, including release.
//   - button_level is 1 in HIGH and WAIT_LOW, 0 in IDLE and WAIT_HIGH.
//   - Latency: if button_raw is 1 at edge k and stays 1, button_pulse is high in the
//     cycle following edge k+D+1.
//   - Counter: unsigned NBITS, compared only for equality with D-1. It never exceeds
//     D-1 and never wraps.
//   - Holding the button never re-triggers a pulse. Another pulse requires a debounced
//     release (IDLE) followed by a new debounced press.
//   - Reset mid-operation: any state returns to IDLE on the reset edge, and a pending
//     count is discarded. If button_raw is still held after reset, the press is
//     re-qualified from scratch: pulse after D+2 edges, counted from the first
//     non-reset edge.
//   - Reset and a qualifying edge in the same cycle: reset wins, no pulse.
//   - All outputs are registered; there is no combinational path from button_raw.
// CONFIGURATION
//   DEBOUNCE_LOCKOUT_EN defined:
//     - Adds port `lockout  in  1`, driven by the FSM `light` output (laser on).
//     - When lockout=1 at the WAIT_HIGH->HIGH edge, the state/level update happens
//       but button_pulse stays 0, so a press during an exposure is swallowed.
//     - lockout has no effect on any other transition.
//   DEBOUNCE_LOCKOUT_EN undefined:
//     - The lockout port does not exist.
//     - Every accepted press produces button_pulse.
// TESTING
//   (Run with D=4.)
//   1 Reset held 3 cycles, raw=0 -> level=0, pulse=0 throughout and after release.
//   2 Raw 0->1 before edge 10, held -> pulse=1 only in cycle after edge 15.
//     level=1 from edge 15 on; no further pulses while held 50 cycles.
//   3 Raw toggles 1,0,1,0 on successive edges, then stays 0 -> pulse never asserted,
//     level stays 0.
//   4 Raw held high: single 1-cycle low glitch while HIGH -> level stays 1, no pulse.
//     Then a clean release of >=6 cycles -> level=0.
//   5 Press accepted, then reset asserted for 1 cycle while raw still 1 -> outputs 0
//     at reset edge. A new pulse appears D+2 edges after reset deasserts.
//   6 (DEBOUNCE_LOCKOUT_EN) lockout=1 during a clean press -> level rises, pulse=0.
//     Same press with lockout=0 -> pulse=1 for one cycle.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Push-button conditioning bus between the board-level button and the debouncer.
// The lockout line exists only when DEBOUNCE_LOCKOUT_EN is defined.
interface button_debouncer_if;
    logic button_raw;
    logic button_level;
    logic button_pulse;
`ifdef DEBOUNCE_LOCKOUT_EN
    logic lockout;
`endif

`ifdef DEBOUNCE_LOCKOUT_EN
    modport master (output button_raw, output lockout, input button_level, input button_pulse);
    modport slave  (input button_raw, input lockout, output button_level, output button_pulse);
`else
    modport master (output button_raw, input button_level, input button_pulse);
    modport slave  (input button_raw, output button_level, output button_pulse);
`endif
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability-counting FSM that turns a bouncing push-button
// into a clean level and a one-cycle press strobe. Optional feature macro: DEBOUNCE_LOCKOUT_EN.
module button_debouncer #(
    parameter int NBITS           = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    button_debouncer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [NBITS-1:0] CNT_ZERO = NBITS'(0);
    localparam logic [NBITS-1:0] CNT_ONE  = NBITS'(1);
    localparam logic [NBITS-1:0] CNT_LAST = NBITS'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    state_t           state_r;
    state_t           state_s;
    logic [NBITS-1:0] cnt_r;
    logic [NBITS-1:0] cnt_s;
    logic             level_r;
    logic             level_s;
    logic             pulse_r;
    logic             pulse_s;
    logic             lockout_s;

`ifdef DEBOUNCE_LOCKOUT_EN
    assign lockout_s = bus.lockout;
`else
    assign lockout_s = 1'b0;
`endif

    // Synchroniser, state, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync1_r <= bus.button_raw;
            sync2_r <= sync1_r;
            state_r <= state_s;
            cnt_r   <= cnt_s;
            level_r <= level_s;
            pulse_r <= pulse_s;
        end
    end

    // Next-state, counter and output decode driven only by the synchronised sample.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        level_s = level_r;
        pulse_s = 1'b0;
        case (state_r)
            IDLE: begin
                level_s = 1'b0;
                if (sync2_r) begin
                    state_s = WAIT_HIGH;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            WAIT_HIGH: begin
                if (!sync2_r) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = HIGH;
                    cnt_s   = CNT_ZERO;
                    level_s = 1'b1;
                    // A press during an exposure still updates the level but is swallowed.
                    pulse_s = ~lockout_s;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            HIGH: begin
                level_s = 1'b1;
                if (!sync2_r) begin
                    state_s = WAIT_LOW;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            WAIT_LOW: begin
                if (sync2_r) begin
                    state_s = HIGH;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                    level_s = 1'b0;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                level_s = 1'b0;
            end
        endcase
    end

    assign bus.button_level = level_r;
    assign bus.button_pulse = pulse_r;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES = 4; outputs sampled 1 time unit after each edge.
module tb_button_debouncer;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    button_debouncer_if bif ();

    button_debouncer #(
        .NBITS           (32),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Press held from the next edge (j=0 is the edge that first samples raw=1).
    task automatic press(input string tag, input int cycles, input logic pulse_on);
        bif.button_raw = 1'b1;
        for (int j = 0; j < cycles; j++) begin
            tick();
            check({tag, "_pulse"}, bif.button_pulse, (j == 5) ? pulse_on : 1'b0);
            check({tag, "_level"}, bif.button_level, (j >= 5) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic release_btn(input string tag, input int cycles);
        bif.button_raw = 1'b0;
        for (int j = 0; j < cycles; j++) begin
            tick();
            check({tag, "_pulse"}, bif.button_pulse, 1'b0);
            check({tag, "_level"}, bif.button_level, (j < 5) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset          = 1'b1;
        bif.button_raw = 1'b0;
`ifdef DEBOUNCE_LOCKOUT_EN
        bif.lockout    = 1'b0;
`endif

        // 1: reset held 3 cycles, then idle low.
        for (int j = 0; j < 3; j++) begin
            tick();
            check("rst_pulse", bif.button_pulse, 1'b0);
            check("rst_level", bif.button_level, 1'b0);
        end
        reset = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            check("idle_pulse", bif.button_pulse, 1'b0);
            check("idle_level", bif.button_level, 1'b0);
        end

        // 2: clean press, held 50 more cycles, single pulse.
        press("press", 56, 1'b1);
        release_btn("rel", 10);

        // 3: toggling bounce is rejected.
        bif.button_raw = 1'b1; tick();
        check("bnc_level", bif.button_level, 1'b0);
        bif.button_raw = 1'b0; tick();
        check("bnc_level", bif.button_level, 1'b0);
        bif.button_raw = 1'b1; tick();
        check("bnc_level", bif.button_level, 1'b0);
        bif.button_raw = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            check("bnc_pulse", bif.button_pulse, 1'b0);
            check("bnc_level", bif.button_level, 1'b0);
        end

        // 4: one-cycle low glitch while high is ignored, then a clean release.
        press("g_press", 8, 1'b1);
        bif.button_raw = 1'b0; tick();
        check("glitch_level", bif.button_level, 1'b1);
        bif.button_raw = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            check("glitch_pulse", bif.button_pulse, 1'b0);
            check("glitch_level", bif.button_level, 1'b1);
        end
        release_btn("g_rel", 8);
        check("g_rel_final", bif.button_level, 1'b0);

        // 5: reset while held, press re-qualified from scratch.
        press("r_press", 8, 1'b1);
        reset = 1'b1; tick();
        check("mid_rst_pulse", bif.button_pulse, 1'b0);
        check("mid_rst_level", bif.button_level, 1'b0);
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            check("requal_pulse", bif.button_pulse, (j == 5) ? 1'b1 : 1'b0);
            check("requal_level", bif.button_level, (j >= 5) ? 1'b1 : 1'b0);
        end
        release_btn("r_rel", 10);

`ifdef DEBOUNCE_LOCKOUT_EN
        // 6: press during lockout is swallowed, the same press without lockout is not.
        bif.lockout = 1'b1;
        press("lk_press", 8, 1'b0);
        release_btn("lk_rel", 8);
        bif.lockout = 1'b0;
        press("nlk_press", 8, 1'b1);
        release_btn("nlk_rel", 8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
